pipeline_debug_ctrl: RTL

PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

---
 rtl/mips_dbg_pkg.sv | 37 +++
 rtl/sat_counter.sv | 34 +++
 rtl/pipeline_debug_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug controller: FSM states, host command
// codes, drain default and the opcodes the debug path cares about.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DUMP   = 3'd4,
        ST_HALTED = 3'd5
    } dbg_state_e;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'b00,
        CMD_STEP  = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_ABORT = 2'b11
    } dbg_cmd_e;

    localparam int unsigned DRAIN_CYCLES_DEF = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    function automatic logic cmd_ready_in(input dbg_state_e s);
        return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HALTED);
    endfunction

    function automatic logic pipe_en_in(input dbg_state_e s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Debug run-control FSM for the MIPS pipeline: run/step/halt-drain/dump
// sequencing driven by host commands, with a saturating executed-cycle count.
module pipeline_debug_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int unsigned NB_CNT       = 32,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    output logic              o_cmd_ready,
    input  logic              i_halt,
    output logic              o_pipe_en,
    output logic              o_pc_clr,
    output logic              o_dump_req,
    input  logic              i_dump_done,
    output logic [2:0]        o_state,
    output logic [NB_CNT-1:0] o_cycle_cnt
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    dbg_state_e    state_q, state_d;
    dbg_state_e    ret_q, ret_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          cmd_ready_q, pipe_en_q, pc_clr_q, dump_req_q;
    logic          clr_pulse;
    logic          hs;
    dbg_cmd_e      cmd;

    assign cmd = dbg_cmd_e'(i_cmd);
    assign hs  = i_cmd_valid & cmd_ready_q;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        drain_d   = drain_q;
        clr_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    case (cmd)
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_CLEAR: clr_pulse = 1'b1;
                        default:   ;
                    endcase
                end
            end
            ST_RUN: begin
                // halt is checked first so a coincident ABORT still drains
                if (i_halt) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                end else if (hs && (cmd == CMD_ABORT)) begin
                    state_d = ST_DUMP;
                    ret_d   = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_d = ST_DUMP;
                ret_d   = i_halt ? ST_HALTED : ST_IDLE;
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DUMP;
                    ret_d   = ST_HALTED;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_DUMP: begin
                if (i_dump_done) begin
                    state_d = ret_q;
                end
            end
            ST_HALTED: begin
                if (hs && (cmd == CMD_CLEAR)) begin
                    clr_pulse = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            drain_q     <= '0;
            cmd_ready_q <= 1'b0;
            pipe_en_q   <= 1'b0;
            pc_clr_q    <= 1'b0;
            dump_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            drain_q     <= drain_d;
            cmd_ready_q <= cmd_ready_in(state_d);
            pipe_en_q   <= pipe_en_in(state_d);
            pc_clr_q    <= clr_pulse;
            dump_req_q  <= (state_d == ST_DUMP);
        end
    end

    sat_counter #(
        .W (NB_CNT)
    ) u_cycle_cnt (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_en    (pipe_en_q),
        .i_clr   (clr_pulse),
        .o_cnt   (o_cycle_cnt)
    );

    assign o_cmd_ready = cmd_ready_q;
    assign o_pipe_en   = pipe_en_q;
    assign o_pc_clr    = pc_clr_q;
    assign o_dump_req  = dump_req_q;
    assign o_state     = state_q;

endmodule
